// File: rtl/sram_arbiter_if.sv
// Request/response bundle between the system interconnect and sram_arbiter.
//   port 0: read-only video fetch   (p0_req/p0_addr -> p0_gnt, p0_rvalid/p0_rdata)
//   port 1: processor read/write    (p1_req/p1_we/p1_addr/p1_wdata/p1_be -> p1_gnt, p1_rvalid/p1_rdata)
// master = requesters' view, slave = arbiter's view.
interface sram_arbiter_if;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;

    logic          p0_req;
    logic [AW-1:0] p0_addr;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic [1:0]    p1_be;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;

    modport master (
        output p0_req, p0_addr,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_be,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata
    );

    modport slave (
        input  p0_req, p0_addr,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_be,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter and access sequencer for a 1M x 16 asynchronous SRAM.
// Port 0 (video, read-only) has priority; port 1 (processor, read/write) wins
// after STARVE_LIMIT consecutive losses. Every access is IDLE -> ACCESS -> HOLD.
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   bus (slave)       request/grant/read-data handshake for both ports
//   SRAM_ADDR         registered SRAM address (holds last value when idle)
//   SRAM_DQ           bidirectional data bus, driven only during writes
//   SRAM_*_N          registered active-low SRAM controls
module sram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sram_arbiter_if.slave        bus,
    output logic [19:0]          SRAM_ADDR,
    inout  wire  [15:0]          SRAM_DQ,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N
);
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Request fields captured at grant; the requester is free afterwards.
    typedef struct packed {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    be;
    } txn_t;

    state_t        state, state_nx;
    txn_t          txn, txn_nx;
    logic [CW-1:0] starve_cnt, starve_nx;

    logic          gnt0, gnt1, p1_win;
    logic [AW-1:0] addr_nx;
    logic          ce_n_nx, oe_n_nx, we_n_nx, ub_n_nx, lb_n_nx;
    logic          dq_en, dq_en_nx;
    logic [DW-1:0] dq_out, dq_out_nx;

    logic          rd_done;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;

    // Next state, arbitration, and the pin values for the state being entered.
    always_comb begin
        state_nx  = state;
        txn_nx    = txn;
        starve_nx = starve_cnt;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        p1_win    = 1'b0;
        addr_nx   = SRAM_ADDR;
        ce_n_nx   = 1'b1;
        oe_n_nx   = 1'b1;
        we_n_nx   = 1'b1;
        ub_n_nx   = 1'b1;
        lb_n_nx   = 1'b1;
        dq_en_nx  = 1'b0;
        dq_out_nx = dq_out;

        case (state)
            ST_IDLE: begin
                // Grants are suppressed while reset is asserted.
                if (reset_n) begin
                    p1_win = bus.p1_req && ((starve_cnt == LIMIT) || !bus.p0_req);
                    gnt1   = p1_win;
                    gnt0   = bus.p0_req && !p1_win;
                end

                if (gnt0) begin
                    txn_nx = '{port: 1'b0, we: 1'b0, addr: bus.p0_addr,
                               wdata: '0, be: '0};
                    if (bus.p1_req && (starve_cnt < LIMIT)) begin
                        starve_nx = starve_cnt + CW'(1);
                    end
                end else if (gnt1) begin
                    txn_nx = '{port: 1'b1, we: bus.p1_we, addr: bus.p1_addr,
                               wdata: bus.p1_wdata, be: bus.p1_be};
                    starve_nx = '0;
                end

                if (gnt0 || gnt1) begin
                    state_nx = ST_ACCESS;
                    addr_nx  = txn_nx.addr;
                    ce_n_nx  = 1'b0;
                    if (txn_nx.we) begin
                        we_n_nx   = 1'b0;
                        ub_n_nx   = ~txn_nx.be[1];
                        lb_n_nx   = ~txn_nx.be[0];
                        dq_en_nx  = 1'b1;
                        dq_out_nx = txn_nx.wdata;
                    end else begin
                        oe_n_nx = 1'b0;
                        ub_n_nx = 1'b0;
                        lb_n_nx = 1'b0;
                    end
                end
            end

            ST_ACCESS: begin
                // Entering HOLD: reads keep OE low; writes raise WE_N only,
                // keeping CE/UB/LB and data for hold time.
                state_nx = ST_HOLD;
                ce_n_nx  = 1'b0;
                if (txn.we) begin
                    ub_n_nx   = ~txn.be[1];
                    lb_n_nx   = ~txn.be[0];
                    dq_en_nx  = 1'b1;
                    dq_out_nx = txn.wdata;
                end else begin
                    oe_n_nx = 1'b0;
                    ub_n_nx = 1'b0;
                    lb_n_nx = 1'b0;
                end
            end

            ST_HOLD: begin
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign rd_done = (state == ST_HOLD) && !txn.we;

    // State, captured request, starvation counter and registered SRAM pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            txn        <= '0;
            starve_cnt <= '0;
            SRAM_ADDR  <= '0;
            SRAM_CE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_WE_N  <= 1'b1;
            SRAM_UB_N  <= 1'b1;
            SRAM_LB_N  <= 1'b1;
            dq_en      <= 1'b0;
            dq_out     <= '0;
        end else begin
            state      <= state_nx;
            txn        <= txn_nx;
            starve_cnt <= starve_nx;
            SRAM_ADDR  <= addr_nx;
            SRAM_CE_N  <= ce_n_nx;
            SRAM_OE_N  <= oe_n_nx;
            SRAM_WE_N  <= we_n_nx;
            SRAM_UB_N  <= ub_n_nx;
            SRAM_LB_N  <= lb_n_nx;
            dq_en      <= dq_en_nx;
            dq_out     <= dq_out_nx;
        end
    end

    // Read data captured on the edge leaving HOLD; rvalid pulses in the next IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= rd_done && !txn.port;
            rvalid1 <= rd_done &&  txn.port;
            if (rd_done && !txn.port) begin
                rdata0 <= SRAM_DQ;
            end
            if (rd_done && txn.port) begin
                rdata1 <= SRAM_DQ;
            end
        end
    end

    assign SRAM_DQ = dq_en ? dq_out : {DW{1'bz}};

    assign bus.p0_gnt    = gnt0;
    assign bus.p1_gnt    = gnt1;
    assign bus.p0_rvalid = rvalid0;
    assign bus.p1_rvalid = rvalid1;
    assign bus.p0_rdata  = rdata0;
    assign bus.p1_rdata  = rdata1;
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised and directed bench for sram_arbiter against a transaction-level
// reference: each accepted request occupies the SRAM for three cycles and reads
// return the reference memory image. A small SRAM device model sits on the pins.
module tb_sram_arbiter;
    localparam int unsigned LIMIT = 4;

    logic clk;
    logic reset_n;
    logic mem_init;

    sram_arbiter_if bus ();

    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;

    sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .SRAM_ADDR (sram_addr),
        .SRAM_DQ   (sram_dq),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .SRAM_WE_N (we_n),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // SRAM device: 256 words, upper address bits alias.
    logic [15:0] dev_mem [256];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? dev_mem[sram_addr[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= 16'(i * 257) ^ 16'h5A5A;
        end else if (reset_n && !ce_n && !we_n) begin
            if (!ub_n) dev_mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
            if (!lb_n) dev_mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
        end
    end

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [15:0] ref_mem [256];
    int          busy;          // cycles remaining in the current access (0 = free)
    int          starve;
    logic        cur_port, cur_we;
    logic [19:0] cur_addr, last_addr;
    logic [15:0] cur_wdata, pend_rdata;
    logic [1:0]  cur_be;
    logic        m_rv0, m_rv1;
    logic [15:0] m_rd0, m_rd1;
    logic        m_g0, m_g1;
    logic        obs_g0, obs_g1;

    task automatic model_reset();
        busy = 0; starve = 0;
        cur_port = 1'b0; cur_we = 1'b0; cur_addr = '0; last_addr = '0;
        cur_wdata = '0; cur_be = '0; pend_rdata = '0;
        m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
        m_g0 = 1'b0; m_g1 = 1'b0;
    endtask

    // Expected pins: {CE_N, OE_N, WE_N, UB_N, LB_N, DQ driven}.
    function automatic logic [5:0] exp_pins();
        if (busy == 0) return 6'b111110;
        if (!cur_we)   return 6'b001000;
        return {1'b0, 1'b1, (busy == 1), ~cur_be[1], ~cur_be[0], 1'b1};
    endfunction

    // One clock cycle: inputs already driven at the preceding negedge.
    task automatic tick();
        #1;
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (busy == 0) begin
            if (bus.p1_req && (starve == LIMIT || !bus.p0_req)) m_g1 = 1'b1;
            else if (bus.p0_req)                                m_g0 = 1'b1;
        end
        obs_g0 = bus.p0_gnt;
        obs_g1 = bus.p1_gnt;
        check("p0_gnt", 32'(obs_g0), 32'(m_g0));
        check("p1_gnt", 32'(obs_g1), 32'(m_g1));
        check("pins", 32'({ce_n, oe_n, we_n, ub_n, lb_n, dut.dq_en}), 32'(exp_pins()));
        check("contention", 32'(dut.dq_en && !oe_n), 32'(0));
        check("addr", 32'(sram_addr), 32'((busy == 0) ? last_addr : cur_addr));
        if (busy != 0 && cur_we) check("dq_wdata", 32'(sram_dq), 32'(cur_wdata));
        check("p0_rvalid", 32'(bus.p0_rvalid), 32'(m_rv0));
        check("p1_rvalid", 32'(bus.p1_rvalid), 32'(m_rv1));
        check("p0_rdata", 32'(bus.p0_rdata), 32'(m_rd0));
        check("p1_rdata", 32'(bus.p1_rdata), 32'(m_rd1));

        // Advance the reference to the next cycle.
        m_rv0 = 1'b0;
        m_rv1 = 1'b0;
        if (busy == 0) begin
            if (m_g0 || m_g1) begin
                cur_port  = m_g1;
                cur_we    = m_g1 ? bus.p1_we    : 1'b0;
                cur_addr  = m_g1 ? bus.p1_addr  : bus.p0_addr;
                cur_wdata = bus.p1_wdata;
                cur_be    = bus.p1_be;
                last_addr = cur_addr;
                if (m_g1) starve = 0;
                else if (bus.p1_req && starve < LIMIT) starve++;
                if (cur_we) begin
                    if (cur_be[1]) ref_mem[cur_addr[7:0]][15:8] = cur_wdata[15:8];
                    if (cur_be[0]) ref_mem[cur_addr[7:0]][7:0]  = cur_wdata[7:0];
                end else begin
                    pend_rdata = ref_mem[cur_addr[7:0]];
                end
                busy = 2;
            end
        end else begin
            busy--;
            if (busy == 0 && !cur_we) begin
                if (cur_port) begin m_rv1 = 1'b1; m_rd1 = pend_rdata; end
                else          begin m_rv0 = 1'b1; m_rd0 = pend_rdata; end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Tick until the given port is granted (bounded), then drop its request.
    task automatic wait_gnt(input logic port);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(port ? obs_g1 : obs_g0) && n < 40);
        check(port ? "p1_gnt_wait" : "p0_gnt_wait", 32'(port ? obs_g1 : obs_g0), 32'(1));
        if (port) bus.p1_req = 1'b0;
        else      bus.p0_req = 1'b0;
    endtask

    task automatic p1_cmd(input logic we, input logic [19:0] a, input logic [15:0] d,
                          input logic [1:0] be);
        bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_be = be;
        wait_gnt(1'b1);
    endtask

    int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int seq     [10];
    int gcyc    [10];
    int gcount;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 257) ^ 16'h5A5A;
        model_reset();
        bus.p0_req = 1'b0; bus.p0_addr = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_be = '0;
        mem_init = 1'b1;
        reset_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pins", 32'({ce_n, oe_n, we_n, ub_n, lb_n, dut.dq_en}), 32'(6'b111110));
        check("rst_addr", 32'(sram_addr), 32'(0));
        check("rst_rvalid", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'(0));
        check("rst_rdata", 32'({bus.p0_rdata, bus.p1_rdata}), 32'(0));
        mem_init = 1'b0;
        reset_n  = 1'b1;

        // Port 0 read of a word preloaded with BEEF.
        p1_cmd(1'b1, 20'h00010, 16'hBEEF, 2'b11);
        ticks(2);
        bus.p0_req = 1'b1; bus.p0_addr = 20'h00010;
        wait_gnt(1'b0);
        ticks(2);
        #1;
        check("beef_rvalid", 32'(bus.p0_rvalid), 32'(1));
        check("beef_rdata", 32'(bus.p0_rdata), 32'(16'hBEEF));
        check("beef_p1_quiet", 32'(bus.p1_rvalid), 32'(0));

        // Lower-byte write over AAAA, then read back.
        p1_cmd(1'b1, 20'h00020, 16'hAAAA, 2'b11);
        ticks(2);
        p1_cmd(1'b1, 20'h00020, 16'h1234, 2'b01);
        ticks(2);
        p1_cmd(1'b0, 20'h00020, 16'h0000, 2'b00);
        ticks(2);
        #1;
        check("be01_rvalid", 32'(bus.p1_rvalid), 32'(1));
        check("be01_rdata", 32'(bus.p1_rdata), 32'(16'hAA34));

        // Write with no byte enables still takes the full sequence.
        p1_cmd(1'b1, 20'h00021, 16'hFFFF, 2'b00);
        ticks(3);

        // Both ports requesting continuously: starvation escape.
        bus.p0_req = 1'b1; bus.p0_addr = 20'h00040;
        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 20'h00050;
        gcount = 0;
        for (int cyc = 0; cyc < 60 && gcount < 10; cyc++) begin
            tick();
            if (obs_g0 || obs_g1) begin
                seq[gcount]  = obs_g1 ? 1 : 0;
                gcyc[gcount] = cyc;
                gcount++;
            end
        end
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        check("starve_grants", 32'(gcount), 32'(10));
        for (int i = 0; i < gcount; i++) begin
            check("starve_seq", 32'(seq[i]), 32'(exp_seq[i]));
            if (i > 0) check("grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'(3));
        end
        ticks(3);

        // Write immediately followed by a read from the other port.
        p1_cmd(1'b1, 20'h00030, 16'h5678, 2'b11);
        bus.p0_req = 1'b1; bus.p0_addr = 20'h00030;
        wait_gnt(1'b0);
        ticks(2);
        #1;
        check("wr_rd_rdata", 32'(bus.p0_rdata), 32'(16'h5678));
        tick();

        // Reset in the ACCESS cycle of a read.
        bus.p0_req = 1'b1; bus.p0_addr = 20'h00011;
        wait_gnt(1'b0);
        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 20'h00060;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_pins", 32'({ce_n, oe_n, we_n, ub_n, lb_n, dut.dq_en}), 32'(6'b111110));
        check("arst_addr", 32'(sram_addr), 32'(0));
        check("arst_gnt", 32'({bus.p0_gnt, bus.p1_gnt}), 32'(0));
        check("arst_rdata", 32'(bus.p0_rdata), 32'(0));
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_gnt(1'b1);
        ticks(4);

        // Long idle stretch.
        for (int i = 0; i < 100; i++) tick();
        check("idle_ce_n", 32'(ce_n), 32'(1));

        // Random traffic from both ports.
        for (int i = 0; i < 1500; i++) begin
            if (!bus.p0_req || obs_g0) begin
                bus.p0_req  = ($urandom_range(0, 2) == 0);
                bus.p0_addr = 20'($urandom);
            end
            if (!bus.p1_req || obs_g1) begin
                bus.p1_req   = ($urandom_range(0, 2) == 0);
                bus.p1_we    = 1'($urandom);
                bus.p1_addr  = 20'($urandom);
                bus.p1_wdata = 16'($urandom);
                bus.p1_be    = 2'($urandom);
            end
            tick();
        end
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        ticks(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
